// File: rtl/mbox_pkg.sv
// -----------------------------------------------------------------------------
// mbox_pkg
// Shared definitions for the MBOX request arbiter: FSM state encoding, MBOX_SRC
// codes, EBOX/MBOX function-bit indices, bus widths and the default watchdog
// limit. Imported by mbox_arb_if, mbox_arb_pick and mbox_arb.
// -----------------------------------------------------------------------------
package mbox_pkg;

  localparam int ADR_W  = 22;
  localparam int FUNC_W = 4;

  // Function bit positions within {LOAD_AR, LOAD_ARX, PAUSE, WRITE}
  localparam int FUNC_WRITE    = 0;
  localparam int FUNC_PAUSE    = 1;
  localparam int FUNC_LOAD_ARX = 2;
  localparam int FUNC_LOAD_AR  = 3;

  // MBOX_SRC codes
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_EBOX = 2'd1;
  localparam logic [1:0] SRC_CHAN = 2'd2;
  localparam logic [1:0] SRC_SWP  = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  // Channel requests only ever load AR (read) or write.
  function automatic logic [FUNC_W-1:0] chan_func(input logic write);
    logic [FUNC_W-1:0] f;
    f               = '0;
    f[FUNC_LOAD_AR] = ~write;
    f[FUNC_WRITE]   = write;
    return f;
  endfunction

endpackage

// File: rtl/mbox_arb_if.sv
// -----------------------------------------------------------------------------
// mbox_arb_if
// Bundles the requester side (EBOX, CHAN, SWP), the MBOX side and the error
// status of the MBOX arbiter.
//   slave  : arbiter view (requests/MBOX handshakes in, MBOX cycle + pulses out)
//   master : environment view (drives requests and MBOX_ACK/DONE/NXM_CLR)
// Signals:
//   ebox_req/ebox_func/ebox_adr, chan_req/chan_write/chan_adr, swp_req/swp_adr
//   mbox_req/mbox_func/mbox_adr/mbox_src, mbox_ack/mbox_done
//   ebox_done/chan_done/swp_done, mb_wait, nxm_err/nxm_clr
// -----------------------------------------------------------------------------
interface mbox_arb_if;
  import mbox_pkg::*;

  logic              ebox_req;
  logic [FUNC_W-1:0] ebox_func;
  logic [ADR_W-1:0]  ebox_adr;
  logic              chan_req;
  logic              chan_write;
  logic [ADR_W-1:0]  chan_adr;
  logic              swp_req;
  logic [ADR_W-1:0]  swp_adr;

  logic              mbox_req;
  logic [FUNC_W-1:0] mbox_func;
  logic [ADR_W-1:0]  mbox_adr;
  logic [1:0]        mbox_src;
  logic              mbox_ack;
  logic              mbox_done;

  logic              ebox_done;
  logic              chan_done;
  logic              swp_done;
  logic              mb_wait;
  logic              nxm_err;
  logic              nxm_clr;

  modport slave (
    input  ebox_req, ebox_func, ebox_adr,
    input  chan_req, chan_write, chan_adr,
    input  swp_req, swp_adr,
    input  mbox_ack, mbox_done, nxm_clr,
    output mbox_req, mbox_func, mbox_adr, mbox_src,
    output ebox_done, chan_done, swp_done, mb_wait, nxm_err
  );

  modport master (
    output ebox_req, ebox_func, ebox_adr,
    output chan_req, chan_write, chan_adr,
    output swp_req, swp_adr,
    output mbox_ack, mbox_done, nxm_clr,
    input  mbox_req, mbox_func, mbox_adr, mbox_src,
    input  ebox_done, chan_done, swp_done, mb_wait, nxm_err
  );
endinterface

// File: rtl/mbox_arb_pick.sv
// -----------------------------------------------------------------------------
// mbox_arb_pick
// Combinational winner select for the MBOX arbiter. Produces the winning
// source code together with the function and address to latch.
// Ports:
//   last_chan  in  (only with MBOX_ARB_RR_EN) CHAN won the last CHAN/EBOX contention
//   lock       in  read-pause-write lock active: only EBOX may win
//   chan_*/ebox_*/swp_*  in  requester inputs
//   src/func/adr         out winner (src = SRC_NONE when nobody requests)
// Build option: MBOX_ARB_RR_EN selects CHAN/EBOX round-robin; SWP stays lowest.
// -----------------------------------------------------------------------------
module mbox_arb_pick
  import mbox_pkg::*;
(
`ifdef MBOX_ARB_RR_EN
  input  logic              last_chan,
`endif
  input  logic              lock,
  input  logic              chan_req,
  input  logic              chan_write,
  input  logic [ADR_W-1:0]  chan_adr,
  input  logic              ebox_req,
  input  logic [FUNC_W-1:0] ebox_func,
  input  logic [ADR_W-1:0]  ebox_adr,
  input  logic              swp_req,
  input  logic [ADR_W-1:0]  swp_adr,
  output logic [1:0]        src,
  output logic [FUNC_W-1:0] func,
  output logic [ADR_W-1:0]  adr
);

  logic chan_ok;
  logic swp_ok;
  logic chan_first;

  assign chan_ok = chan_req & ~lock;
  assign swp_ok  = swp_req & ~lock;

  // In round-robin mode the loser of the previous contention goes first.
`ifdef MBOX_ARB_RR_EN
  assign chan_first = ~last_chan;
`else
  assign chan_first = 1'b1;
`endif

  always_comb begin
    src  = SRC_NONE;
    func = '0;
    adr  = '0;
    if (chan_ok && (chan_first || !ebox_req)) begin
      src  = SRC_CHAN;
      func = chan_func(chan_write);
      adr  = chan_adr;
    end else if (ebox_req) begin
      src  = SRC_EBOX;
      func = ebox_func;
      adr  = ebox_adr;
    end else if (swp_ok) begin
      src  = SRC_SWP;
      func = '0;
      adr  = swp_adr;
    end
  end

endmodule

// File: rtl/mbox_arb.sv
// -----------------------------------------------------------------------------
// mbox_arb
// Arbitrates EBOX, channel and cache-sweep requests onto the single MBOX
// request port, tracks the MBOX cycle, returns one-cycle DONE pulses to the
// requester, implements the EBOX read-pause-write lock and an MBOX response
// watchdog with a sticky NXM error.
// Parameters:
//   TIMEOUT  watchdog limit in clk cycles (8-bit counter, <= 255)
// Ports:
//   clk    in  clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    mbox_arb_if.slave (requests, MBOX handshake, DONE pulses, MB_WAIT,
//          NXM_ERR/NXM_CLR)
// Build option: MBOX_ARB_RR_EN enables CHAN/EBOX round-robin with a last-grant
// flop; without it CHAN > EBOX > SWP fixed priority.
// -----------------------------------------------------------------------------
module mbox_arb
  import mbox_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic       clk,
  input logic       rst_n,
  mbox_arb_if.slave bus
);

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [1:0]        src_q, src_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              lock_q, lock_d;
  logic              nxm_q;
  logic              cyc_done;
  logic              wd_expired;
  logic              ebox_done_w;

  logic [1:0]        pick_src;
  logic [FUNC_W-1:0] pick_func;
  logic [ADR_W-1:0]  pick_adr;

`ifdef MBOX_ARB_RR_EN
  logic last_chan_q;

  // Remember who won the last genuine CHAN/EBOX contention in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_chan_q <= 1'b0;
    end else if (state_q == S_IDLE && bus.chan_req && bus.ebox_req) begin
      last_chan_q <= (pick_src == SRC_CHAN);
    end
  end
`endif

  mbox_arb_pick u_pick (
`ifdef MBOX_ARB_RR_EN
    .last_chan  (last_chan_q),
`endif
    .lock       (state_q == S_PAUSE),
    .chan_req   (bus.chan_req),
    .chan_write (bus.chan_write),
    .chan_adr   (bus.chan_adr),
    .ebox_req   (bus.ebox_req),
    .ebox_func  (bus.ebox_func),
    .ebox_adr   (bus.ebox_adr),
    .swp_req    (bus.swp_req),
    .swp_adr    (bus.swp_adr),
    .src        (pick_src),
    .func       (pick_func),
    .adr        (pick_adr)
  );

  // The watchdog fires in the cycle the counter reads TIMEOUT, i.e. after
  // TIMEOUT full cycles in REQ or WAIT. MBOX_DONE in that same cycle takes the
  // normal completion path, so no error is raised. The lock is held across
  // non-write EBOX cycles and dropped by a completed write or a timeout.
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    adr_d      = adr_q;
    src_d      = src_q;
    lock_d     = lock_q;
    cnt_d      = '0;
    cyc_done   = 1'b0;
    wd_expired = 1'b0;

    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (pick_src != SRC_NONE) begin
          func_d  = pick_func;
          adr_d   = pick_adr;
          src_d   = pick_src;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mbox_ack) begin
          state_d = S_WAIT;
        end else if (cnt_q == WD_LIMIT) begin
          wd_expired = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mbox_done) begin
          cyc_done = 1'b1;
          if (func_q[FUNC_WRITE]) begin
            lock_d = 1'b0;
          end else if (src_q == SRC_EBOX && func_q[FUNC_PAUSE]) begin
            lock_d = 1'b1;
          end
          state_d = lock_d ? S_PAUSE : S_IDLE;
        end else if (cnt_q == WD_LIMIT) begin
          wd_expired = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wd_expired) begin
      cyc_done = 1'b1;
      lock_d   = 1'b0;
      state_d  = S_IDLE;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      adr_q   <= '0;
      src_q   <= SRC_NONE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      adr_q   <= adr_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      if (wd_expired) begin
        nxm_q <= 1'b1;
      end else if (bus.nxm_clr) begin
        nxm_q <= 1'b0;
      end
    end
  end

  // MBOX_REQ and the DONE pulses decode the state directly so that reset
  // removes them immediately, without waiting for a clock edge.
  assign ebox_done_w   = cyc_done && (src_q == SRC_EBOX);
  assign bus.ebox_done = ebox_done_w;
  assign bus.chan_done = cyc_done && (src_q == SRC_CHAN);
  assign bus.swp_done  = cyc_done && (src_q == SRC_SWP);
  assign bus.mbox_req  = (state_q == S_REQ);
  assign bus.mbox_func = func_q;
  assign bus.mbox_adr  = adr_q;
  assign bus.mbox_src  = src_q;
  assign bus.mb_wait   = bus.ebox_req & ~ebox_done_w;
  assign bus.nxm_err   = nxm_q;

endmodule

// File: tb/tb_mbox_arb.sv
// -----------------------------------------------------------------------------
// tb_mbox_arb
// Self-checking bench for mbox_arb: a vector table of single-requester and
// non-contending cases plus hand-written sequences for contention, the
// read-pause-write lock, the watchdog, DONE/timeout coincidence and reset.
// Expected grants go into a scoreboard queue when requests are driven and are
// popped when MBOX_REQ appears. Honours MBOX_ARB_RR_EN for the contention case.
// -----------------------------------------------------------------------------
module tb_mbox_arb;
  import mbox_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mbox_arb_if bus();

  mbox_arb #(.TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic              chan_req;
    logic              chan_write;
    logic [ADR_W-1:0]  chan_adr;
    logic              ebox_req;
    logic [FUNC_W-1:0] ebox_func;
    logic [ADR_W-1:0]  ebox_adr;
    logic              swp_req;
    logic [ADR_W-1:0]  swp_adr;
    logic [1:0]        exp_src;
    logic [FUNC_W-1:0] exp_func;
    logic [ADR_W-1:0]  exp_adr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_grant(input logic [1:0] src, input logic [3:0] func,
                                       input logic [21:0] adr);
    sb_q.push_back({4'b0, src, func, adr});
  endfunction

  function automatic logic [2:0] done_mask(input logic [1:0] src);
    case (src)
      SRC_EBOX: return 3'b100;
      SRC_CHAN: return 3'b010;
      SRC_SWP:  return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] done_vec();
    return {29'b0, bus.ebox_done, bus.chan_done, bus.swp_done};
  endfunction

  task automatic check_grant(input string name);
    logic [31:0] exp;
    check_output({name, "_req"}, {31'b0, bus.mbox_req}, 32'd1);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_sb: got grant src %0d, expected none queued", name, bus.mbox_src);
    end else begin
      exp = sb_q.pop_front();
      check_output({name, "_grant"}, {4'b0, bus.mbox_src, bus.mbox_func, bus.mbox_adr}, exp);
    end
  endtask

  // ACK, wait gap cycles in WAIT, then DONE; checks the pulse and its end.
  task automatic finish_cycle(input string name, input logic [1:0] src, input int gap);
    bus.mbox_ack = 1'b1;
    tick();
    bus.mbox_ack = 1'b0;
    #1;
    check_output({name, "_req_low"}, {31'b0, bus.mbox_req}, 32'd0);
    repeat (gap) tick();
    bus.mbox_done = 1'b1;
    #1;
    check_output({name, "_done"}, done_vec(), {29'b0, done_mask(src)});
    tick();
    bus.mbox_done = 1'b0;
    #1;
    check_output({name, "_done_clr"}, done_vec(), 32'd0);
  endtask

  task automatic drop_all();
    bus.chan_req = 1'b0;
    bus.ebox_req = 1'b0;
    bus.swp_req  = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    bus.chan_req   = v.chan_req;
    bus.chan_write = v.chan_write;
    bus.chan_adr   = v.chan_adr;
    bus.ebox_req   = v.ebox_req;
    bus.ebox_func  = v.ebox_func;
    bus.ebox_adr   = v.ebox_adr;
    bus.swp_req    = v.swp_req;
    bus.swp_adr    = v.swp_adr;
    expect_grant(v.exp_src, v.exp_func, v.exp_adr);
    #1;
    check_output({nm, "_no_req_yet"}, {31'b0, bus.mbox_req}, 32'd0);
    tick();
    check_grant(nm);
    drop_all();
    finish_cycle(nm, v.exp_src, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    logic [1:0] first_src, second_src;

    vecs[0] = '{1'b0, 1'b0, 22'o0,    1'b1, 4'b1000, 22'o1000, 1'b0, 22'o0,   SRC_EBOX, 4'b1000, 22'o1000};
    vecs[1] = '{1'b1, 1'b0, 22'o2345, 1'b0, 4'b0000, 22'o0,    1'b0, 22'o0,   SRC_CHAN, 4'b1000, 22'o2345};
    vecs[2] = '{1'b1, 1'b1, 22'o3456, 1'b0, 4'b0000, 22'o0,    1'b0, 22'o0,   SRC_CHAN, 4'b0001, 22'o3456};
    vecs[3] = '{1'b0, 1'b0, 22'o0,    1'b0, 4'b0000, 22'o0,    1'b1, 22'o777, SRC_SWP,  4'b0000, 22'o777};
    vecs[4] = '{1'b0, 1'b0, 22'o0,    1'b1, 4'b0100, 22'o11,   1'b1, 22'o22,  SRC_EBOX, 4'b0100, 22'o11};
    vecs[5] = '{1'b1, 1'b1, 22'o33,   1'b0, 4'b0000, 22'o0,    1'b1, 22'o44,  SRC_CHAN, 4'b0001, 22'o33};

    rst_n          = 1'b0;
    bus.ebox_req   = 1'b0;
    bus.ebox_func  = '0;
    bus.ebox_adr   = '0;
    bus.chan_req   = 1'b0;
    bus.chan_write = 1'b0;
    bus.chan_adr   = '0;
    bus.swp_req    = 1'b0;
    bus.swp_adr    = '0;
    bus.mbox_ack   = 1'b0;
    bus.mbox_done  = 1'b0;
    bus.nxm_clr    = 1'b0;

    // Reset state
    #3;
    check_output("rst_mbox_req", {31'b0, bus.mbox_req}, 32'd0);
    check_output("rst_mbox_src", {30'b0, bus.mbox_src}, 32'd0);
    check_output("rst_nxm_err", {31'b0, bus.nxm_err}, 32'd0);
    check_output("rst_done", done_vec(), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic EBOX read with MB_WAIT tracking
    bus.ebox_req  = 1'b1;
    bus.ebox_func = 4'b1000;
    bus.ebox_adr  = 22'o1000;
    expect_grant(SRC_EBOX, 4'b1000, 22'o1000);
    #1;
    check_output("b_mb_wait_idle", {31'b0, bus.mb_wait}, 32'd1);
    tick();
    check_grant("b");
    bus.mbox_ack = 1'b1;
    tick();
    bus.mbox_ack = 1'b0;
    tick();
    tick();
    check_output("b_mb_wait_hold", {31'b0, bus.mb_wait}, 32'd1);
    check_output("b_no_done_early", done_vec(), 32'd0);
    bus.mbox_done = 1'b1;
    #1;
    check_output("b_ebox_done", done_vec(), 32'h4);
    check_output("b_mb_wait_fall", {31'b0, bus.mb_wait}, 32'd0);
    tick();
    bus.mbox_done = 1'b0;
    bus.ebox_req  = 1'b0;
    #1;
    check_output("b_done_clr", done_vec(), 32'd0);
    check_output("b_idle_req", {31'b0, bus.mbox_req}, 32'd0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // CHAN/EBOX contention, requests held until their DONE
    bus.chan_req   = 1'b1;
    bus.chan_write = 1'b0;
    bus.chan_adr   = 22'o100;
    bus.ebox_req   = 1'b1;
    bus.ebox_func  = 4'b1000;
    bus.ebox_adr   = 22'o200;
    expect_grant(SRC_CHAN, 4'b1000, 22'o100);
    expect_grant(SRC_EBOX, 4'b1000, 22'o200);
    tick();
    check_grant("c1");
    finish_cycle("c1", SRC_CHAN, 1);
    bus.chan_req = 1'b0;
    tick();
    check_grant("c2");
    finish_cycle("c2", SRC_EBOX, 1);
    bus.ebox_req = 1'b0;

    bus.chan_req  = 1'b1;
    bus.chan_adr  = 22'o300;
    bus.ebox_req  = 1'b1;
    bus.ebox_adr  = 22'o400;
`ifdef MBOX_ARB_RR_EN
    first_src  = SRC_EBOX;
    second_src = SRC_CHAN;
    expect_grant(SRC_EBOX, 4'b1000, 22'o400);
    expect_grant(SRC_CHAN, 4'b1000, 22'o300);
`else
    first_src  = SRC_CHAN;
    second_src = SRC_EBOX;
    expect_grant(SRC_CHAN, 4'b1000, 22'o300);
    expect_grant(SRC_EBOX, 4'b1000, 22'o400);
`endif
    tick();
    check_grant("c3");
    finish_cycle("c3", first_src, 1);
    if (first_src == SRC_CHAN) bus.chan_req = 1'b0;
    else bus.ebox_req = 1'b0;
    tick();
    check_grant("c4");
    finish_cycle("c4", second_src, 1);
    drop_all();

    // Read-pause-write lock
    bus.ebox_req  = 1'b1;
    bus.ebox_func = 4'b1010;
    bus.ebox_adr  = 22'o500;
    expect_grant(SRC_EBOX, 4'b1010, 22'o500);
    tick();
    check_grant("d_rd");
    finish_cycle("d_rd", SRC_EBOX, 1);
    bus.ebox_req   = 1'b0;
    bus.chan_req   = 1'b1;
    bus.chan_write = 1'b0;
    bus.chan_adr   = 22'o600;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_output($sformatf("d_lock%0d", k), {31'b0, bus.mbox_req}, 32'd0);
    end
    bus.ebox_req  = 1'b1;
    bus.ebox_func = 4'b0001;
    expect_grant(SRC_EBOX, 4'b0001, 22'o500);
    expect_grant(SRC_CHAN, 4'b1000, 22'o600);
    #1;
    check_output("d_mb_wait_pause", {31'b0, bus.mb_wait}, 32'd1);
    tick();
    check_grant("d_wr");
    finish_cycle("d_wr", SRC_EBOX, 1);
    bus.ebox_req = 1'b0;
    tick();
    check_grant("d_chan");
    finish_cycle("d_chan", SRC_CHAN, 1);
    drop_all();

    // Watchdog: no ACK
    bus.ebox_req  = 1'b1;
    bus.ebox_func = 4'b1000;
    bus.ebox_adr  = 22'o700;
    expect_grant(SRC_EBOX, 4'b1000, 22'o700);
    tick();
    check_grant("e");
    n = 0;
    while (n < 300 && bus.ebox_done !== 1'b1) begin
      tick();
      n++;
    end
    check_output("e_timeout_cycles", 32'(n), 32'd255);
    check_output("e_err_not_yet", {31'b0, bus.nxm_err}, 32'd0);
    bus.ebox_req = 1'b0;
    tick();
    check_output("e_nxm_set", {31'b0, bus.nxm_err}, 32'd1);
    check_output("e_idle", {31'b0, bus.mbox_req}, 32'd0);
    check_output("e_done_clr", done_vec(), 32'd0);
    bus.nxm_clr = 1'b1;
    tick();
    bus.nxm_clr = 1'b0;
    check_output("e_nxm_clr", {31'b0, bus.nxm_err}, 32'd0);

    // MBOX_DONE coinciding with the watchdog limit
    bus.ebox_req = 1'b1;
    bus.ebox_adr = 22'o710;
    expect_grant(SRC_EBOX, 4'b1000, 22'o710);
    tick();
    check_grant("f");
    bus.mbox_ack = 1'b1;
    tick();
    bus.mbox_ack = 1'b0;
    repeat (254) tick();
    check_output("f_no_early_timeout", done_vec(), 32'd0);
    tick();
    bus.mbox_done = 1'b1;
    #1;
    check_output("f_done", done_vec(), 32'h4);
    tick();
    bus.mbox_done = 1'b0;
    bus.ebox_req  = 1'b0;
    #1;
    check_output("f_nxm_clear", {31'b0, bus.nxm_err}, 32'd0);
    check_output("f_done_clr", done_vec(), 32'd0);

    // Reset during REQ: MBOX_REQ drops without a clock edge
    bus.ebox_req = 1'b1;
    bus.ebox_adr = 22'o720;
    tick();
    check_output("g_req_up", {31'b0, bus.mbox_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("g_req_async_low", {31'b0, bus.mbox_req}, 32'd0);
    check_output("g_src_reset", {30'b0, bus.mbox_src}, 32'd0);
    bus.ebox_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_output("g_idle1", {31'b0, bus.mbox_req}, 32'd0);

    // Reset during WAIT with MBOX_DONE asserted: no DONE pulse
    bus.ebox_req = 1'b1;
    tick();
    bus.mbox_ack = 1'b1;
    tick();
    bus.mbox_ack  = 1'b0;
    bus.mbox_done = 1'b1;
    rst_n         = 1'b0;
    #1;
    check_output("g_no_done", done_vec(), 32'd0);
    check_output("g_wait_req_low", {31'b0, bus.mbox_req}, 32'd0);
    bus.mbox_done = 1'b0;
    bus.ebox_req  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_output("g_idle2_req", {31'b0, bus.mbox_req}, 32'd0);
    check_output("g_idle2_src", {30'b0, bus.mbox_src}, 32'd0);
    check_output("g_idle2_done", done_vec(), 32'd0);

    check_output("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbox_arb.md
MBOX_ARB -- requirements
Module: mbox_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: MBOX response watchdog limit in clk cycles (8-bit counter).
REQ-002 clk  in  1  EBOX clock; all state on posedge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 EBOX_REQ  in  1  EBOX cycle request (MCL MBOX_CYC_REQ); level, held until EBOX_DONE.
REQ-005 EBOX_FUNC  in  4  {LOAD_AR, LOAD_ARX, PAUSE, WRITE} from MCL.
REQ-006 EBOX_ADR  in  22  physical address.
REQ-007 CHAN_REQ / CHAN_WRITE  in  1/1  channel request (level) and direction.
REQ-008 CHAN_ADR  in  22  channel address.
REQ-009 SWP_REQ  in  1, SWP_ADR  in  22  cache-sweep request and address.
REQ-010 MBOX_REQ  out  1  cycle request to MBOX.
REQ-011 MBOX_FUNC  out  4, MBOX_ADR  out  22, MBOX_SRC  out  2 (0 none, 1 EBOX, 2 CHAN, 3 SWP).
REQ-012 MBOX_ACK  in  1  MBOX accepted request; MBOX_DONE  in  1  cycle complete.
REQ-013 EBOX_DONE, CHAN_DONE, SWP_DONE  out  1 each  one-cycle completion pulses.
REQ-014 MB_WAIT  out  1  EBOX stall: EBOX_REQ high and EBOX cycle not yet done.
REQ-015 NXM_ERR  out  1  sticky watchdog error; NXM_CLR  in  1  clears it.

Function
REQ-016 States IDLE, REQ, WAIT, PAUSE; encoding from shared package.
REQ-017 IDLE: with any request, latch winner's FUNC/ADR/SRC and enter REQ next cycle; no request -> stay IDLE.
REQ-018 Priority (fixed): CHAN > EBOX > SWP; CHAN FUNC = {~W, 0, 0, W}; SWP FUNC = 4'b0000.
REQ-019 REQ: MBOX_REQ=1, MBOX_FUNC/ADR/SRC stable from latches; MBOX_ACK -> WAIT.
REQ-020 WAIT: MBOX_REQ=0; MBOX_DONE -> pulse <SRC>_DONE same cycle, then IDLE, or PAUSE if latched EBOX FUNC has PAUSE=1 and WRITE=0.
REQ-021 PAUSE (read-pause-write lock): CHAN and SWP ignored; EBOX_REQ -> latch EBOX, enter REQ; lock ends only on completion of the EBOX write.
REQ-022 Minimum latency request -> MBOX_REQ: 1 cycle; DONE pulse in cycle MBOX_DONE is sampled.
REQ-023 Watchdog counts each cycle in REQ or WAIT, clears on state entry; at TIMEOUT: set NXM_ERR, pulse <SRC>_DONE, go IDLE, release PAUSE lock.
REQ-024 Timeout and MBOX_DONE in same cycle: DONE wins, no error.
REQ-025 NXM_CLR and error set in same cycle: set wins.
REQ-026 MB_WAIT = EBOX_REQ & ~EBOX_DONE; high in PAUSE when EBOX_REQ high.
REQ-027 Requester dropping REQ after latch does not abort; cycle runs to DONE.

Reset
REQ-028 RESET_N low: state IDLE; MBOX_REQ, all DONE pulses, NXM_ERR, counter, latches, last-grant 0; MBOX_SRC=0.
REQ-029 Reset mid-cycle (REQ/WAIT/PAUSE): immediate return to IDLE, MBOX_REQ deasserts asynchronously, no DONE pulse.

Configuration
REQ-030 Macro MBOX_ARB_RR_EN defined: CHAN and EBOX round-robin via last-grant bit (loser of previous contention wins next); SWP stays lowest.
REQ-031 Macro absent: fixed priority per REQ-018; no last-grant flop.

Structure
REQ-032 Shared package mbox_pkg: state enum, MBOX_SRC codes, FUNC bit indices, default TIMEOUT.
REQ-033 One sub-module mbox_arb_pick: combinational winner select (priority/RR), instantiated once.

Verification
REQ-034 EBOX_REQ, FUNC=1000, ADR=0o1000 -> MBOX_REQ next cycle, ADR 0o1000, SRC=1; ACK, DONE 3 cycles later -> EBOX_DONE one pulse, MB_WAIT falls.
REQ-035 CHAN_REQ and EBOX_REQ same cycle -> CHAN granted first (SRC=2); with MBOX_ARB_RR_EN, second contention grants EBOX.
REQ-036 EBOX FUNC=1010 read, DONE -> PAUSE; CHAN_REQ held 10 cycles ignored; EBOX FUNC=0001 write completes -> CHAN granted next.
REQ-037 No ACK for 255 cycles -> NXM_ERR=1, EBOX_DONE pulse, IDLE; NXM_CLR -> NXM_ERR=0.
REQ-038 RESET_N low during WAIT -> MBOX_REQ=0, no DONE pulse, IDLE after release.
REQ-039 DONE and timeout coincide at count 255 -> DONE pulse, NXM_ERR stays 0.
